pwm_timer_multi: RTL and testbench
==================================

# pwm_timer_multi

Parametrised multi-channel timer/PWM generator for the elevator SoC peripheral set (motor drive, door actuator, buzzer, periodic tick). One shared prescaler and period counter drive CH independent compare channels. Each channel produces a PWM output and a sticky compare-match interrupt. A sticky overflow interrupt is also provided. Prescaler, period and compare values are shadowed and take effect only at start or at period wrap, so software updates never produce glitches. A one-shot mode stops the timer after a single period.

## Interface
Parameters:
- CH, 4, number of compare/PWM channels (1..8)
- W, 32, width of the prescaler, period, compare and count values

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run, 0 = stop and clear the counters
- one_shot  in  1  1 = stop after the first wrap
- prescaler  in  W  tick every prescaler+1 clk cycles
- period  in  W  counter counts 0..period
- compare  in  CH*W  channel i compare value at bits [i*W +: W]
- ch_en  in  CH  per-channel output and compare-interrupt enable
- polarity  in  CH  1 = invert output; idle level equals polarity[i]
- ovf_clr  in  1  single-cycle pulse, clears irq_ovf
- cmp_clr  in  CH  single-cycle pulse per bit, clears irq_cmp[i]
- pwm_out  out  CH  PWM outputs, driven from flops
- irq_ovf  out  1  sticky overflow flag
- irq_cmp  out  CH  sticky compare-match flags
- count  out  W  current counter value
- running  out  1  1 while in RUN

## Operation
- **States:**
  - IDLE: enable=1 moves to RUN.
  - RUN: enable=0 moves to IDLE. A wrap with one_shot=1 moves to DONE.
  - DONE: enable=0 moves to IDLE. One-shot restart requires enable to go low, then high.
- **Entering RUN:** load the active registers from prescaler, period and compare. Clear pres_cnt and count to 0.
- **In RUN:**
  - tick = (pres_cnt == prescaler_act). On a tick, pres_cnt returns to 0; otherwise it increments.
  - On a tick, count increments. When count == period_act, the tick is a wrap: count returns to 0.
- **Shadow reload:** at every wrap, reload all active registers from the inputs. Mid-period input changes have no effect before then.
- **PWM output:**
  - Enabled channel: pwm_out[i] = (count < cmp_act[i]) XOR polarity[i].
  - Disabled channel, or state not RUN: pwm_out[i] = polarity[i].
  - Equivalently, the output is at active level during counts 0..cmp_act-1.
- **Duty boundaries:**
  - cmp_act = 0: duty is 0% (output never leaves idle level).
  - cmp_act > period_act: duty is 100%.
- **Overflow interrupt:** irq_ovf sets on every wrap.
- **Compare interrupt:** irq_cmp[i] sets on a tick that makes count == cmp_act[i], with ch_en[i]=1 and cmp_act[i] ≤ period_act.
  - cmp_act[i] = 0 sets the flag on the wrap tick.
- **Flag clear:** flags hold until their clear bit pulses. If set and clear occur in the same cycle, set wins.
- **Flags persist** across enable=0 and state changes. Only reset clears them.
- **Arithmetic:** all comparisons are unsigned, W bits wide.
- **Extreme settings:**
  - prescaler = 0: a tick occurs every clk.
  - period = 0: every tick is a wrap and count stays 0.

## Timing
- **Reset values:** state=IDLE, pres_cnt=0, count=0, all active registers=0, running=0, pwm_out=0, irq_ovf=0, irq_cmp=0.
- From the first clk edge after reset deasserts, pwm_out follows the idle rule.
- **Start:** at the edge where enable=1 is sampled in IDLE, running=1 and count=0 appear after that same edge. The first tick occurs prescaler_act+1 cycles later.
- **Period length:** (period_act+1)*(prescaler_act+1) clk cycles.
- **Output latency:** pwm_out, count and the irq flags are registered together. pwm_out reflects the count of the same cycle, with zero additional latency.
- **Stop:** at the edge where enable=0 is sampled:
  - running=0 and count=0 next cycle;
  - pwm_out goes to idle level next cycle;
  - a tick due in that same cycle is discarded.
- **One-shot:** after the wrap edge the timer is in DONE. running=0, count=0, and irq_ovf sets on the same edge.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous).

## Test plan
- **Basic PWM:** CH=4, W=32. Set prescaler=1, period=9, compare0=3, ch_en=0001, polarity=0, enable=1. Expect pwm_out[0] high for 6 clk of every 20. Expect irq_ovf to set every 20 clk, and irq_cmp[0] to set when count reaches 3.
- **Duty extremes:** compare1=0, compare2=10, compare3=5, polarity3=1. Expect pwm_out[1]=0 constantly, pwm_out[2]=1 constantly, and pwm_out[3] low for counts 0..4 and high for counts 5..9.
- **Shadowing:** change compare0 from 3 to 7 at count=5. Expect the current period to keep a high time of 3 counts; expect 7 counts from the next wrap.
- **One-shot:** set one_shot=1, enable=1. Expect exactly one period, then running=0, count=0, irq_ovf=1. With enable held at 1, no restart. Toggling enable 0→1 restarts.
- **Interrupts:** assert ovf_clr in the same cycle as a wrap; expect irq_ovf to stay 1. Assert ovf_clr one cycle later; expect irq_ovf=0. Deassert enable; expect irq_cmp flags unchanged.
- **Reset mid-run:** assert reset at count=4. Expect all outputs at their reset values immediately. Expect a restart from count=0 once enable is reasserted after reset is released.

Source files
------------

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: one shared prescaler/period counter, CH compare channels,
// shadowed settings reloaded at start and at every period wrap, optional one-shot mode.
module pwm_timer_multi #(
    parameter int CH = 4,
    parameter int W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            one_shot,
    input  logic [W-1:0]    prescaler,
    input  logic [W-1:0]    period,
    input  logic [CH*W-1:0] compare,
    input  logic [CH-1:0]   ch_en,
    input  logic [CH-1:0]   polarity,
    input  logic            ovf_clr,
    input  logic [CH-1:0]   cmp_clr,
    output logic [CH-1:0]   pwm_out,
    output logic            irq_ovf,
    output logic [CH-1:0]   irq_cmp,
    output logic [W-1:0]    count,
    output logic            running,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = 1;

    state_t               st, st_n;
    logic [W-1:0]         pres_cnt, pres_n;
    logic [W-1:0]         count_n;
    logic [W-1:0]         presc_act, presc_n;
    logic [W-1:0]         period_act, period_n;
    logic [CH-1:0][W-1:0] cmp_act, cmp_n;
    logic                 tick;
    logic                 wrap;
    logic                 ovf_set;
    logic [CH-1:0]        cmp_set;
    logic [CH-1:0]        pwm_n;

    assign state = st;

    always_comb begin
        st_n     = st;
        pres_n   = pres_cnt;
        count_n  = count;
        presc_n  = presc_act;
        period_n = period_act;
        cmp_n    = cmp_act;
        tick     = 1'b0;
        wrap     = 1'b0;
        ovf_set  = 1'b0;
        cmp_set  = '0;
        pwm_n    = polarity;

        case (st)
            IDLE: begin
                if (enable) begin
                    st_n     = RUN;
                    pres_n   = '0;
                    count_n  = '0;
                    presc_n  = prescaler;
                    period_n = period;
                    for (int i = 0; i < CH; i++) cmp_n[i] = compare[i*W +: W];
                end
            end
            RUN: begin
                if (!enable) begin
                    // Stopping discards any tick that was due this cycle.
                    st_n    = IDLE;
                    pres_n  = '0;
                    count_n = '0;
                end else begin
                    tick = (pres_cnt == presc_act);
                    if (tick) begin
                        pres_n = '0;
                        wrap   = (count == period_act);
                        if (wrap) begin
                            count_n  = '0;
                            ovf_set  = 1'b1;
                            presc_n  = prescaler;
                            period_n = period;
                            for (int i = 0; i < CH; i++) cmp_n[i] = compare[i*W +: W];
                            if (one_shot) st_n = DONE;
                        end else begin
                            count_n = count + ONE;
                        end
                        // Match uses the settings of the period that is ending.
                        for (int i = 0; i < CH; i++) begin
                            if (ch_en[i] && (cmp_act[i] <= period_act) && (count_n == cmp_act[i]))
                                cmp_set[i] = 1'b1;
                        end
                    end else begin
                        pres_n = pres_cnt + ONE;
                    end
                end
            end
            DONE: begin
                pres_n  = '0;
                count_n = '0;
                if (!enable) st_n = IDLE;
            end
            default: begin
                st_n    = IDLE;
                pres_n  = '0;
                count_n = '0;
            end
        endcase

        // Output is computed from next-cycle values so it lines up with count.
        for (int i = 0; i < CH; i++) begin
            if ((st_n == RUN) && ch_en[i])
                pwm_n[i] = (count_n < cmp_n[i]) ^ polarity[i];
            else
                pwm_n[i] = polarity[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            pres_cnt   <= '0;
            count      <= '0;
            presc_act  <= '0;
            period_act <= '0;
            cmp_act    <= '0;
            running    <= 1'b0;
            pwm_out    <= '0;
            irq_ovf    <= 1'b0;
            irq_cmp    <= '0;
        end else begin
            st         <= st_n;
            pres_cnt   <= pres_n;
            count      <= count_n;
            presc_act  <= presc_n;
            period_act <= period_n;
            cmp_act    <= cmp_n;
            running    <= (st_n == RUN);
            pwm_out    <= pwm_n;
            irq_ovf    <= (irq_ovf & ~ovf_clr) | ovf_set;
            irq_cmp    <= (irq_cmp & ~cmp_clr) | cmp_set;
        end
    end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi: a cycle-indexed vector table for the basic PWM run,
// followed by hand-written sequences for clears, shadowing, stop, one-shot and reset.
module tb_pwm_timer_multi;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            one_shot;
    logic [W-1:0]    prescaler;
    logic [W-1:0]    period;
    logic [CH*W-1:0] compare;
    logic [CH-1:0]   ch_en;
    logic [CH-1:0]   polarity;
    logic            ovf_clr;
    logic [CH-1:0]   cmp_clr;
    logic [CH-1:0]   pwm_out;
    logic            irq_ovf;
    logic [CH-1:0]   irq_cmp;
    logic [W-1:0]    count;
    logic            running;
    logic [1:0]      state;

    pwm_timer_multi #(.CH(CH), .W(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .one_shot(one_shot),
        .prescaler(prescaler), .period(period), .compare(compare),
        .ch_en(ch_en), .polarity(polarity), .ovf_clr(ovf_clr), .cmp_clr(cmp_clr),
        .pwm_out(pwm_out), .irq_ovf(irq_ovf), .irq_cmp(irq_cmp),
        .count(count), .running(running), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [31:0] cnt;
        logic [3:0]  pwm;
        logic        ovf;
        logic [3:0]  cmp;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int k);
        while (cur < k) begin
            step();
            cur++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmp(input int i, input logic [W-1:0] v);
        compare[i*W +: W] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle k is measured from the edge where enable=1 is first sampled.
        vecs[0] = '{0,  0, 4'b0101, 1'b0, 4'b0000};
        vecs[1] = '{1,  0, 4'b0101, 1'b0, 4'b0000};
        vecs[2] = '{5,  2, 4'b0101, 1'b0, 4'b0000};
        vecs[3] = '{6,  3, 4'b0100, 1'b0, 4'b0001};
        vecs[4] = '{9,  4, 4'b0100, 1'b0, 4'b0001};
        vecs[5] = '{10, 5, 4'b1100, 1'b0, 4'b1001};
        vecs[6] = '{19, 9, 4'b1100, 1'b0, 4'b1001};
        vecs[7] = '{20, 0, 4'b0101, 1'b1, 4'b1011};
        vecs[8] = '{21, 0, 4'b0101, 1'b1, 4'b1011};
        vecs[9] = '{26, 3, 4'b0100, 1'b1, 4'b1011};

        reset     = 1'b1;
        enable    = 1'b0;
        one_shot  = 1'b0;
        prescaler = 1;
        period    = 9;
        compare   = '0;
        set_cmp(0, 3);
        set_cmp(1, 0);
        set_cmp(2, 10);
        set_cmp(3, 5);
        ch_en     = 4'b1111;
        polarity  = 4'b1000;
        ovf_clr   = 1'b0;
        cmp_clr   = '0;
        step();
        step();
        chk("reset_count", count, 0);
        chk("reset_running", running, 0);
        chk("reset_pwm", pwm_out, 0);
        chk("reset_ovf", irq_ovf, 0);
        chk("reset_cmp", irq_cmp, 0);
        chk("reset_state", state, 0);

        reset = 1'b0;
        step();
        chk("idle_pwm", pwm_out, 4'b1000);
        chk("idle_running", running, 0);

        enable = 1'b1;
        step();
        cur = 0;
        chk("start_running", running, 1);
        for (int v = 0; v < 10; v++) begin
            go_to(vecs[v].k);
            chk($sformatf("vec%0d_count", v), count, vecs[v].cnt);
            chk($sformatf("vec%0d_pwm", v), pwm_out, vecs[v].pwm);
            chk($sformatf("vec%0d_ovf", v), irq_ovf, vecs[v].ovf);
            chk($sformatf("vec%0d_cmp", v), irq_cmp, vecs[v].cmp);
            chk($sformatf("vec%0d_running", v), running, 1);
        end

        // Flag clears, including clear colliding with a wrap.
        go_to(27);
        ovf_clr = 1'b1;
        step(); cur++;
        ovf_clr = 1'b0;
        chk("ovf_clear", irq_ovf, 0);
        cmp_clr = 4'b1111;
        step(); cur++;
        cmp_clr = 4'b0000;
        chk("cmp_clear", irq_cmp, 4'b0000);
        go_to(30);
        chk("cmp3_reset_after_clear", irq_cmp, 4'b1000);
        go_to(39);
        ovf_clr = 1'b1;
        step(); cur++;
        ovf_clr = 1'b0;
        chk("ovf_set_wins", irq_ovf, 1);
        chk("wrap2_count", count, 0);
        chk("wrap2_cmp", irq_cmp, 4'b1010);
        ovf_clr = 1'b1;
        step(); cur++;
        ovf_clr = 1'b0;
        chk("ovf_clear_after_wrap", irq_ovf, 0);

        // Shadowing: compare0 changed mid-period applies from the next wrap.
        go_to(50);
        chk("shadow_mid_count", count, 5);
        set_cmp(0, 7);
        go_to(54);
        chk("shadow_old_count", count, 7);
        chk("shadow_old_pwm0", pwm_out[0], 0);
        go_to(60);
        chk("shadow_wrap_ovf", irq_ovf, 1);
        chk("shadow_new_pwm0_start", pwm_out[0], 1);
        go_to(73);
        chk("shadow_new_count6", count, 6);
        chk("shadow_new_pwm0_high", pwm_out[0], 1);
        go_to(74);
        chk("shadow_new_pwm0_low", pwm_out[0], 0);
        chk("pre_stop_cmp", irq_cmp, 4'b1011);

        // Stop.
        enable = 1'b0;
        step();
        chk("stop_running", running, 0);
        chk("stop_count", count, 0);
        chk("stop_pwm", pwm_out, 4'b1000);
        chk("stop_cmp_persist", irq_cmp, 4'b1011);
        chk("stop_ovf_persist", irq_ovf, 1);
        chk("stop_state", state, 0);

        // One-shot.
        ovf_clr = 1'b1;
        cmp_clr = 4'b1111;
        step();
        ovf_clr = 1'b0;
        cmp_clr = 4'b0000;
        chk("os_pre_ovf", irq_ovf, 0);
        chk("os_pre_cmp", irq_cmp, 0);
        prescaler = 0;
        period    = 3;
        set_cmp(0, 2);
        ch_en     = 4'b0001;
        polarity  = 4'b0000;
        one_shot  = 1'b1;
        step();
        chk("os_idle_pwm", pwm_out, 4'b0000);
        enable = 1'b1;
        step();
        chk("os_k0_running", running, 1);
        chk("os_k0_pwm", pwm_out, 4'b0001);
        step();
        step();
        chk("os_k2_count", count, 2);
        chk("os_k2_pwm", pwm_out, 4'b0000);
        chk("os_k2_cmp", irq_cmp, 4'b0001);
        step();
        chk("os_k3_count", count, 3);
        chk("os_k3_ovf", irq_ovf, 0);
        step();
        chk("os_done_running", running, 0);
        chk("os_done_count", count, 0);
        chk("os_done_ovf", irq_ovf, 1);
        chk("os_done_state", state, 2);
        for (int i = 0; i < 5; i++) step();
        chk("os_hold_running", running, 0);
        chk("os_hold_count", count, 0);
        one_shot = 1'b0;
        period   = 9;
        enable   = 1'b0;
        step();
        chk("os_toggle_idle", state, 0);
        enable = 1'b1;
        step();
        chk("os_restart_running", running, 1);
        chk("os_restart_count", count, 0);

        // Reset mid-run at count 4.
        begin
            int budget = 50;
            while (count != 4 && budget > 0) begin
                step();
                budget--;
            end
            chk("reach_count4_timeout", (budget > 0), 1);
        end
        chk("pre_reset_running", running, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_count", count, 0);
        chk("async_reset_running", running, 0);
        chk("async_reset_pwm", pwm_out, 0);
        chk("async_reset_ovf", irq_ovf, 0);
        chk("async_reset_cmp", irq_cmp, 0);
        enable   = 1'b0;
        polarity = 4'b0110;
        step();
        reset = 1'b0;
        step();
        chk("post_reset_running", running, 0);
        chk("post_reset_pwm", pwm_out, 4'b0110);
        enable = 1'b1;
        step();
        chk("rerun_running", running, 1);
        chk("rerun_count", count, 0);
        chk("rerun_pwm", pwm_out, 4'b0111);
        step();
        step();
        chk("rerun_count2", count, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
